// File: rtl/seq_shift_add_multiplier.sv
// Sequential radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH over WIDTH cycles.
// Optional two's-complement mode enabled by defining SEQ_MULT_SIGNED_EN.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// BUSY  | one add/shift step per cycle, WIDTH steps
// DONE  | product presented on out_p until out_ready
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic                 in_signed,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_count;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [2*WIDTH-1:0]   w_acc_final;
  logic                 w_last;

`ifdef SEQ_MULT_SIGNED_EN
  logic r_neg;
  logic w_a_neg;
  logic w_b_neg;

  // Operands become magnitudes at acceptance; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits.
  assign w_a_neg     = in_signed & in_a[WIDTH-1];
  assign w_b_neg     = in_signed & in_b[WIDTH-1];
  assign w_a_mag     = w_a_neg ? (~in_a + WIDTH'(1)) : in_a;
  assign w_b_mag     = w_b_neg ? (~in_b + WIDTH'(1)) : in_b;
  assign w_acc_final = r_neg ? (~w_acc_next + (2*WIDTH)'(1)) : w_acc_next;
`else
  assign w_a_mag     = in_a;
  assign w_b_mag     = in_b;
  assign w_acc_final = w_acc_next;
`endif

  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                    + (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
  assign w_last     = (r_count == CW'(WIDTH-1));
  assign out_p      = r_acc;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      r_neg    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_acc    <= '0;
            r_count  <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            r_neg    <= w_a_neg ^ w_b_neg;
`endif
          end
        end
        BUSY: begin
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + CW'(1);
          // Sign correction is folded into the final step so DONE sees the finished value.
          r_acc    <= w_last ? w_acc_final : w_acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier (WIDTH=8); signed cases run when
// SEQ_MULT_SIGNED_EN is defined.
module tb_seq_shift_add_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_p;
  logic           busy;
  logic           in_signed;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  seq_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef SEQ_MULT_SIGNED_EN
    .in_signed (in_signed),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic sgn);
    longint sa, sb, p;
    sa = longint'(a);
    sb = longint'(b);
    if (sgn) begin
      if (a[W-1]) sa = sa - (longint'(1) << W);
      if (b[W-1]) sb = sb - (longint'(1) << W);
    end
    p = sa * sb;
    return p[2*W-1:0];
  endfunction

  // Accept one operand pair, check latency, then wait hold cycles with out_ready=0 before consuming.
  task automatic run_mult(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sgn, input int hold, input logic pulse_busy);
    int cyc;
    logic [2*W-1:0] exp;
    exp = ref_prod(a, b, sgn);
    cyc = 0;
    while (!in_ready && cyc < 50) begin tick(); cyc++; end
    chk({tag, "_ready"}, in_ready, 1'b1);
    in_a = a; in_b = b; in_signed = sgn; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      if (pulse_busy) begin
        in_valid = cyc[0];
        in_a = 8'hFF; in_b = 8'hFF;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, 64'(cyc), 64'(W));
    chk({tag, "_prod"}, out_p, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      if (i == hold - 1 || hold > 10) begin
        chk({tag, "_hold_valid"}, out_valid, 1'b1);
        chk({tag, "_hold_prod"}, out_p, exp);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_consumed"}, out_valid, 1'b0);
    chk({tag, "_idle_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    int cyc;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0; in_signed = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_p", out_p, '0);
    chk("rst_busy", busy, 1'b0);

    run_mult("m13x11", 8'd13, 8'd11, 1'b0, 0, 1'b0);
    run_mult("allones", 8'hFF, 8'hFF, 1'b0, 0, 1'b0);
    chk("allones_const", ref_prod(8'hFF, 8'hFF, 1'b0), 16'hFE01);
    run_mult("zero_pulse", 8'd0, 8'd200, 1'b0, 0, 1'b1);
    run_mult("backpressure", 8'd13, 8'd11, 1'b0, 20, 1'b0);

    // Busy flag during operation.
    in_a = 8'd9; in_b = 8'd9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("busy_high", busy, 1'b1);
    chk("busy_not_ready", in_ready, 1'b0);
    cyc = 0;
    while (!out_valid && cyc < 100) begin tick(); cyc++; end
    chk("busy_prod", out_p, 16'd81);
    chk("done_not_ready", in_ready, 1'b0);
    // in_valid and out_ready together in DONE: only the result is consumed.
    in_a = 8'd7; in_b = 8'd7; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("done_both_valid", out_valid, 1'b0);
    chk("done_both_busy", busy, 1'b0);
    chk("done_both_ready", in_ready, 1'b1);

    // Reset mid-operation at count=4.
    in_a = 8'd200; in_b = 8'd100; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_ready", in_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_out_p", out_p, '0);
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) cyc++;
      tick();
    end
    chk("midrst_no_valid", 64'(cyc), 64'd0);
    run_mult("after_rst", 8'd3, 8'd5, 1'b0, 0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (k == 0) ra = '0;
      if (k == 1) rb = 8'h80;
      run_mult("rand", ra, rb, 1'b0, int'($urandom_range(0, 3)), 1'b0);
    end

`ifdef SEQ_MULT_SIGNED_EN
    run_mult("s_m7x6", 8'hF9, 8'h06, 1'b1, 0, 1'b0);
    chk("s_m7x6_const", ref_prod(8'hF9, 8'h06, 1'b1), 16'hFFD6);
    run_mult("s_m128sq", 8'h80, 8'h80, 1'b1, 0, 1'b0);
    chk("s_m128sq_const", ref_prod(8'h80, 8'h80, 1'b1), 16'h4000);
    run_mult("s_unsigned", 8'hF9, 8'h06, 1'b0, 0, 1'b0);
    chk("s_unsigned_const", ref_prod(8'hF9, 8'h06, 1'b0), 16'd1494);
    for (int k = 0; k < 10; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_mult("s_rand", ra, rb, 1'($urandom), 0, 1'b0);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
